// File: rtl/gray_counter_if.sv
// Control and status bundle for gray_counter: count/load controls in,
// registered binary count, Gray pointer and wrap pulse out.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] binary;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  modport master (
    output en, up, load, load_bin,
    input  binary, gray, wrap
  );

  modport slave (
    input  en, up, load, load_bin,
    output binary, gray, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-coded copy, suitable as a
// glitch-free pointer source for clock-domain crossings.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  gray_counter_if.slave bus
);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_r;

  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (bus.load) begin
      cnt_nxt = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        cnt_nxt  = cnt + 1'b1;
        wrap_nxt = &cnt;
      end else begin
        cnt_nxt  = cnt - 1'b1;
        wrap_nxt = ~|cnt;
      end
    end
  end

  // Gray is registered from the next count so the output pin never sees a
  // combinational decode and flips exactly one bit per count step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      gray_r <= '0;
      wrap_r <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      gray_r <= bin2gray(cnt_nxt);
      wrap_r <= wrap_nxt;
    end
  end

  assign bus.binary = cnt;
  assign bus.gray   = gray_r;
  assign bus.wrap   = wrap_r;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: WIDTH=4 directed scenarios plus a
// WIDTH=8 randomized run with asynchronous resets.
module tb_gray_counter;

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] gray;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rst8 = 1'b1;
  int   checks = 0;
  int   failures = 0;

  exp_t q4[$];
  exp_t q8[$];
  logic [3:0] m4 = '0;
  logic [7:0] m8 = '0;

  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(4)) if4 ();
  gray_counter_if #(.WIDTH(8)) if8 ();

  gray_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));
  gray_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));

  function automatic logic [7:0] gray_model(input logic [7:0] b, input int w);
    logic [7:0] g;
    g = '0;
    g[w-1] = b[w-1];
    for (int i = 0; i < w - 1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  function automatic logic [7:0] gray_decode(input logic [7:0] g, input int w);
    logic [7:0] b;
    b = '0;
    b[w-1] = g[w-1];
    for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drives one cycle on the 4-bit DUT, pushes the model result, then pops
  // and compares it one cycle later. Called at posedge+1.
  task automatic step4(input logic e, input logic u, input logic l, input logic [3:0] lb);
    exp_t x;
    logic w;
    if4.en = e; if4.up = u; if4.load = l; if4.load_bin = lb;
    w = 1'b0;
    if (l) m4 = lb;
    else if (e) begin
      w  = u ? (m4 == 4'hF) : (m4 == 4'h0);
      m4 = u ? m4 + 4'd1 : m4 - 4'd1;
    end
    x.bin = {4'b0, m4}; x.gray = gray_model({4'b0, m4}, 4); x.wrap = w;
    q4.push_back(x);
    @(posedge clk); #1;
    x = q4.pop_front();
    checks++;
    if (if4.binary !== x.bin[3:0]) begin
      failures++; $display("FAIL step4_binary got=%b exp=%b", if4.binary, x.bin[3:0]);
    end
    checks++;
    if (if4.gray !== x.gray[3:0]) begin
      failures++; $display("FAIL step4_gray got=%b exp=%b", if4.gray, x.gray[3:0]);
    end
    checks++;
    if (if4.wrap !== x.wrap) begin
      failures++; $display("FAIL step4_wrap got=%b exp=%b", if4.wrap, x.wrap);
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({if4.binary, if4.gray, if4.wrap} !== 9'b0) begin
      failures++; $display("FAIL reset_held got=%b/%b/%b exp=0", if4.binary, if4.gray, if4.wrap);
    end
    rst4 = 1'b0; m4 = '0;
    for (int i = 0; i < 3; i++) step4(1'b1, 1'b1, 1'b0, 4'h0);
    #2 rst4 = 1'b1;
    #1;
    checks++;
    if ({if4.binary, if4.gray, if4.wrap} !== 9'b0) begin
      failures++; $display("FAIL reset_async got=%b/%b/%b exp=0", if4.binary, if4.gray, if4.wrap);
    end
    @(posedge clk); #1;
    checks++;
    if ({if4.binary, if4.gray, if4.wrap} !== 9'b0) begin
      failures++; $display("FAIL reset_hold_en got=%b/%b/%b exp=0", if4.binary, if4.gray, if4.wrap);
    end
    rst4 = 1'b0; m4 = '0;
    if4.en = 1'b0;
  endtask

  task automatic test_count_up;
    logic [3:0] seq [17];
    logic [3:0] prev;
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    checks++;
    if (if4.gray !== seq[0]) begin
      failures++; $display("FAIL up_start got=%b exp=%b", if4.gray, seq[0]);
    end
    for (int i = 1; i < 17; i++) begin
      prev = if4.gray;
      step4(1'b1, 1'b1, 1'b0, 4'h0);
      checks++;
      if (if4.gray !== seq[i]) begin
        failures++; $display("FAIL up_seq[%0d] got=%b exp=%b", i, if4.gray, seq[i]);
      end
      checks++;
      if ($countones(prev ^ if4.gray) != 1) begin
        failures++; $display("FAIL up_onebit[%0d] got=%0d exp=1", i, $countones(prev ^ if4.gray));
      end
    end
  endtask

  task automatic test_count_down;
    step4(1'b0, 1'b0, 1'b1, 4'h0);
    step4(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if ({if4.binary, if4.gray, if4.wrap} !== {4'b1111, 4'b1000, 1'b1}) begin
      failures++; $display("FAIL down_wrap got=%b/%b/%b exp=1111/1000/1", if4.binary, if4.gray, if4.wrap);
    end
    step4(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if ({if4.binary, if4.gray, if4.wrap} !== {4'b1110, 4'b1001, 1'b0}) begin
      failures++; $display("FAIL down_next got=%b/%b/%b exp=1110/1001/0", if4.binary, if4.gray, if4.wrap);
    end
  endtask

  task automatic test_load_priority;
    step4(1'b1, 1'b1, 1'b1, 4'b1010);
    checks++;
    if ({if4.binary, if4.gray, if4.wrap} !== {4'b1010, 4'b1111, 1'b0}) begin
      failures++; $display("FAIL load_prio got=%b/%b/%b exp=1010/1111/0", if4.binary, if4.gray, if4.wrap);
    end
    step4(1'b1, 1'b1, 1'b0, 4'h0);
    checks++;
    if ({if4.binary, if4.gray} !== {4'b1011, 4'b1110}) begin
      failures++; $display("FAIL load_then_up got=%b/%b exp=1011/1110", if4.binary, if4.gray);
    end
    step4(1'b1, 1'b1, 1'b1, 4'b1111);
    checks++;
    if (if4.wrap !== 1'b0) begin
      failures++; $display("FAIL load_no_wrap got=%b exp=0", if4.wrap);
    end
  endtask

  task automatic test_hold_reverse;
    logic [3:0] rev [4];
    rev = '{4'b0110, 4'b0101, 4'b0110, 4'b0101};
    step4(1'b0, 1'b0, 1'b1, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      step4(1'b0, 1'b1, 1'b0, 4'h0);
      checks++;
      if (if4.gray !== 4'b0111) begin
        failures++; $display("FAIL hold[%0d] got=%b exp=0111", i, if4.gray);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step4(1'b1, (i % 2 == 0), 1'b0, 4'h0);
      checks++;
      if (if4.binary !== rev[i]) begin
        failures++; $display("FAIL reverse[%0d] got=%b exp=%b", i, if4.binary, rev[i]);
      end
    end
  endtask

  task automatic test_random;
    exp_t x;
    logic e, u, l, w;
    logic [7:0] lb;
    rst8 = 1'b0; m8 = '0;
    for (int c = 0; c < 1000; c++) begin
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1);
      l  = ($urandom_range(0, 9) == 0);
      lb = 8'($urandom);
      if8.en = e; if8.up = u; if8.load = l; if8.load_bin = lb;
      if ($urandom_range(0, 49) == 0) begin
        #2 rst8 = 1'b1;
        #1;
        checks++;
        if ({if8.binary, if8.gray, if8.wrap} !== 17'b0) begin
          failures++; $display("FAIL rnd_rst_async[%0d] got=%h/%h/%b exp=0", c, if8.binary, if8.gray, if8.wrap);
        end
        @(posedge clk); #1;
        checks++;
        if ({if8.binary, if8.gray, if8.wrap} !== 17'b0) begin
          failures++; $display("FAIL rnd_rst_edge[%0d] got=%h/%h/%b exp=0", c, if8.binary, if8.gray, if8.wrap);
        end
        #1 rst8 = 1'b0;
        m8 = '0;
      end else begin
        w = 1'b0;
        if (l) m8 = lb;
        else if (e) begin
          w  = u ? (m8 == 8'hFF) : (m8 == 8'h00);
          m8 = u ? m8 + 8'd1 : m8 - 8'd1;
        end
        x.bin = m8; x.gray = gray_model(m8, 8); x.wrap = w;
        q8.push_back(x);
        @(posedge clk); #1;
        x = q8.pop_front();
        checks++;
        if (if8.binary !== x.bin || if8.wrap !== x.wrap) begin
          failures++; $display("FAIL rnd_model[%0d] got=%h/%b exp=%h/%b", c, if8.binary, if8.wrap, x.bin, x.wrap);
        end
        checks++;
        if (if8.gray !== (if8.binary ^ (if8.binary >> 1))) begin
          failures++; $display("FAIL rnd_encode[%0d] got=%h exp=%h", c, if8.gray, if8.binary ^ (if8.binary >> 1));
        end
        checks++;
        if (gray_decode(if8.gray, 8) !== if8.binary) begin
          failures++; $display("FAIL rnd_decode[%0d] got=%h exp=%h", c, gray_decode(if8.gray, 8), if8.binary);
        end
      end
    end
    if8.en = 1'b0; if8.load = 1'b0;
  endtask

  initial begin
    if4.en = 1'b0; if4.up = 1'b0; if4.load = 1'b0; if4.load_bin = '0;
    if8.en = 1'b0; if8.up = 1'b0; if8.load = 1'b0; if8.load_bin = '0;
    test_reset;
    test_count_up;
    test_count_down;
    test_load_priority;
    test_hold_reverse;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parameterized up/down counter that keeps a binary count and drives its Gray-coded equivalent from a register. It performs binary-to-Gray encoding, the inverse of our 4-bit Gray-to-binary decoder. Successive `gray` values differ in exactly one bit and the output is glitch-free, so it can serve as a pointer source for clock-domain-crossing logic such as async FIFO read/write pointers. The far side decodes it with the Gray-to-binary block.

## Interface
- `WIDTH`, default 4: counter and output width in bits; legal for values ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: count enable; advance one step per cycle while high.
- `up` input 1: direction; 1 = increment, 0 = decrement; sampled only when counting.
- `load` input 1: synchronous load of `load_bin`.
- `load_bin` input WIDTH: binary load value.
- `binary` output WIDTH: registered binary count.
- `gray` output WIDTH: registered Gray code of `binary`; `gray = binary ^ (binary >> 1)`.
- `wrap` output 1: registered one-cycle pulse when a count step wraps.

## Operation
- State is the internal binary count `cnt[WIDTH-1:0]`. `binary` mirrors `cnt`.
- `gray` is a separate register, loaded with the encoding of the next `cnt` value. It is never a combinational decode of `cnt` at the output pin.
- Per-cycle priority, highest first:
  - `load=1`: `cnt <= load_bin`; `gray <= load_bin ^ (load_bin>>1)`; `wrap <= 0`. `en` and `up` are ignored.
  - `load=0`, `en=1`, `up=1`: `cnt <= cnt+1`, modulo 2^WIDTH. `wrap <= 1` iff the old `cnt` was all ones.
  - `load=0`, `en=1`, `up=0`: `cnt <= cnt-1`, modulo 2^WIDTH. `wrap <= 1` iff the old `cnt` was zero.
  - `load=0`, `en=0`: hold `cnt` and `gray`; `wrap <= 0`.
- Arithmetic:
  - Width is exactly WIDTH bits, with natural wrap-around and no saturation.
  - No carry or borrow output apart from `wrap`.
- Encoding:
  - Bit WIDTH-1 of `gray` equals bit WIDTH-1 of `binary`.
  - Every lower bit i is `binary[i+1] ^ binary[i]`.
- Single-bit-change guarantee: during counting (no load, no reset), consecutive `gray` values differ in exactly one bit, including across the wrap. A load may change any number of bits.
- Direction reversal is allowed on any cycle. The next step uses the new `up` value, with no bubble.

## Timing
- Reset (async assert, takes effect without a clock edge): `cnt=0`, `binary=0`, `gray=0`, `wrap=0`.
- Reset deassertion: the first state change can occur on the first rising `clk` edge after `rst` falls.
- Latency:
  - `en` or `load` sampled at edge N: `binary`, `gray` and `wrap` all reflect the result after edge N. This is one cycle of latency.
  - `binary` and `gray` always change on the same edge, so they are mutually consistent every cycle.
- `wrap` is high for exactly one cycle per wrapping step. With `en` held high and `WIDTH=4` counting up, `wrap` pulses once every 16 cycles.
- Reset mid-count: all outputs go to their reset values immediately. A pending `load` or `en` in that cycle is discarded.
- `load` and `en` asserted in the same cycle: the load wins, no count step is applied, and `wrap=0`.

## Test plan
- Reset: with `WIDTH=4`, assert `rst` asynchronously between clock edges. Required: `binary=0000`, `gray=0000` and `wrap=0` before the next edge; outputs stay there while `rst` is high.
- Count up: hold `en=1`, `up=1` for 17 cycles from 0. Required:
  - `gray` sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - `wrap=1` only on the 15→0 step.
  - Every transition changes exactly 1 bit.
- Count down: from 0, one cycle with `en=1`, `up=0`. Required: `binary=1111`, `gray=1000`, `wrap=1`. Next step gives `binary=1110`, `gray=1001`, `wrap=0`.
- Load priority: `load=1`, `load_bin=1010`, `en=1`, `up=1` in one cycle. Required: `binary=1010`, `gray=1111`, `wrap=0`. Then one count-up step gives `binary=1011`, `gray=1110`.
- Hold and reversal:
  - Set `binary=0101` and drop `en` for 3 cycles. Required: `gray=0111` is stable.
  - Then alternate `up` each cycle with `en=1`. Required: `binary` sequence 0110, 0101, 0110, 0101.
- Reset mid-count plus cross-check: randomly toggle `en`, `up` and `load` for 1000 cycles with `WIDTH=8`, and assert `rst` asynchronously at random points. Required:
  - `gray` equals `binary ^ (binary>>1)` every cycle.
  - The Gray-to-binary decode of `gray` equals `binary`.
  - Outputs equal 0 whenever `rst` is high.
